// File: rtl/fixmul_pkg.sv
// Shared types and constants for the sequential fixed-point multiplier.
// Saturation on overflow is enabled by defining FIXMUL_SAT_EN.
package fixmul_pkg;

  localparam int DEFAULT_Q_BITS  = 10;
  localparam int DEFAULT_D_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic logic [63:0] rnd_const(input int q);
    return 64'(1) << (q - 1);
  endfunction

endpackage

// File: rtl/fixmul_round_sat.sv
// Rounds an unsigned magnitude, applies sign, then wraps or clamps.
// Clamping is built only when FIXMUL_SAT_EN is defined.
module fixmul_round_sat
  import fixmul_pkg::*;
#(
  parameter int Q_BITS  = DEFAULT_Q_BITS,
  parameter int D_WIDTH = DEFAULT_D_WIDTH
) (
  input  logic [2*D_WIDTH-1:0] acc,
  input  logic                 sign,
  output logic [D_WIDTH-1:0]   product
);

  localparam int AW = 2 * D_WIDTH + 1;
  localparam logic [AW-1:0] NEG_LIM = AW'(1) << (D_WIDTH - 1);
  localparam logic [AW-1:0] POS_LIM = NEG_LIM - AW'(1);

  logic [AW-1:0]      sum;
  logic [AW-1:0]      r;
  logic [D_WIDTH-1:0] r_lo;
  logic               neg;
  logic               pos_ovf;
  logic               neg_ovf;
  logic               sat_en;

  // Extra top bit keeps the rounding add from overflowing.
  assign sum  = {1'b0, acc} + AW'(rnd_const(Q_BITS));
  assign r    = sum >> Q_BITS;
  assign r_lo = r[D_WIDTH-1:0];
  assign neg  = sign && (r != '0);

  assign pos_ovf = !neg && (r > POS_LIM);
  assign neg_ovf = neg && (r > NEG_LIM);

`ifdef FIXMUL_SAT_EN
  assign sat_en = 1'b1;
`else
  assign sat_en = 1'b0;
`endif

  always_comb begin
    product = neg ? (~r_lo + 1'b1) : r_lo;
    if (sat_en && pos_ovf) begin
      product = {1'b0, {(D_WIDTH-1){1'b1}}};
    end else if (sat_en && neg_ovf) begin
      product = {1'b1, {(D_WIDTH-1){1'b0}}};
    end
  end

endmodule

// File: rtl/fixmul_seq.sv
// Shift-add signed fixed-point multiplier, one multiplier bit per cycle.
// Optional output clamp via FIXMUL_SAT_EN (see fixmul_round_sat).
module fixmul_seq
  import fixmul_pkg::*;
#(
  parameter int Q_BITS  = DEFAULT_Q_BITS,
  parameter int D_WIDTH = DEFAULT_D_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] multiplicand,
  input  logic [D_WIDTH-1:0] multiplier,
  input  logic               valid_in,
  output logic               ready_in,
  output logic [D_WIDTH-1:0] product,
  output logic               valid_out,
  input  logic               ready_out
);

  localparam int CW = $clog2(D_WIDTH);
  localparam int AW = 2 * D_WIDTH;

  state_e             state_q, state_d;
  logic [D_WIDTH-1:0] a_mag_q, a_mag_d;
  logic [D_WIDTH-1:0] b_mag_q, b_mag_d;
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [D_WIDTH-1:0] prod_q, prod_d;
  logic               vout_q, vout_d;

  logic [D_WIDTH-1:0] a_abs;
  logic [D_WIDTH-1:0] b_abs;
  logic [AW-1:0]      part;
  logic [AW-1:0]      acc_nxt;
  logic [D_WIDTH-1:0] rs_prod;

  // Unsigned view makes the most negative value map to 2^(D_WIDTH-1).
  assign a_abs = multiplicand[D_WIDTH-1] ? (~multiplicand + 1'b1)
                                         : multiplicand;
  assign b_abs = multiplier[D_WIDTH-1] ? (~multiplier + 1'b1)
                                       : multiplier;

  assign part    = {{D_WIDTH{1'b0}}, a_mag_q} << cnt_q;
  assign acc_nxt = b_mag_q[cnt_q] ? (acc_q + part) : acc_q;

  fixmul_round_sat #(
    .Q_BITS  (Q_BITS),
    .D_WIDTH (D_WIDTH)
  ) u_round_sat (
    .acc     (acc_nxt),
    .sign    (sign_q),
    .product (rs_prod)
  );

  assign ready_in  = (state_q == IDLE);
  assign valid_out = vout_q;
  assign product   = prod_q;

  always_comb begin
    state_d = state_q;
    a_mag_d = a_mag_q;
    b_mag_d = b_mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    prod_d  = prod_q;
    vout_d  = vout_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          a_mag_d = a_abs;
          b_mag_d = b_abs;
          sign_d  = multiplicand[D_WIDTH-1]
                  ^ multiplier[D_WIDTH-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(D_WIDTH - 1)) begin
          prod_d  = rs_prod;
          vout_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_out) begin
          vout_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_mag_q <= '0;
      b_mag_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      prod_q  <= '0;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_mag_q <= a_mag_d;
      b_mag_q <= b_mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      prod_q  <= prod_d;
      vout_q  <= vout_d;
    end
  end

endmodule

// File: tb/tb_fixmul_seq.sv
// Scoreboard bench for fixmul_seq (Q_BITS=10, D_WIDTH=32).
// Expected values adapt to FIXMUL_SAT_EN.
module tb_fixmul_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] product;
  logic        valid_out;
  logic        ready_out;

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   cmp_n = 0;
  int   fail_n = 0;

  fixmul_seq dut (
    .clock        (clock),
    .reset        (reset),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .product      (product),
    .valid_out    (valid_out),
    .ready_out    (ready_out)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: pops on every output handshake.
  initial begin : monitor
    int   rise_cyc;
    logic prev_v;
    exp_t e;
    rise_cyc = 0;
    prev_v   = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        prev_v = 1'b0;
      end else begin
        if (valid_out && !prev_v) rise_cyc = cyc;
        if (valid_out && ready_out) begin
          if (q.size() == 0) begin
            chk("unexpected_out", product, 32'hxxxx_xxxx);
          end else begin
            e = q.pop_front();
            chk("product", product, e.exp);
            chk("latency", 32'(rise_cyc - e.acc), 32'd32);
          end
        end
        prev_v = valid_out;
      end
    end
  end

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] e);
    int n;
    n = 0;
    @(negedge clock);
    while (!ready_in && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!ready_in) begin
      chk("issue_timeout", {31'd0, ready_in}, 32'd1);
      return;
    end
    multiplicand = a;
    multiplier   = b;
    valid_in     = 1'b1;
    @(posedge clock);
    #1;
    q.push_back('{exp: e, acc: cyc});
    valid_in     = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clock);
      #2;
      n++;
    end
    if (q.size() != 0) begin
      chk("done_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clock);
    #2;
    chk("vout_one_cycle", {31'd0, valid_out}, 32'd0);
    chk("idle_ready", {31'd0, ready_in}, 32'd1);
  endtask

  logic [31:0] va[9];
  logic [31:0] vb[9];
  logic [31:0] ve[9];

  initial begin : stim
    exp_t dropped;
    int   n;
    reset        = 1'b0;
    valid_in     = 1'b0;
    ready_out    = 1'b1;
    multiplicand = '0;
    multiplier   = '0;

    va[0] = 32'd1536;        vb[0] = 32'd2048;  ve[0] = 32'd3072;
    va[1] = -32'sd1536;      vb[1] = 32'd2048;  ve[1] = -32'sd3072;
    va[2] = 32'd0;           vb[2] = -32'sd2048; ve[2] = 32'd0;
    va[3] = 32'd1;           vb[3] = 32'd512;   ve[3] = 32'd1;
    va[4] = 32'd1;           vb[4] = 32'd511;   ve[4] = 32'd0;
    va[5] = -32'sd1;         vb[5] = 32'd512;   ve[5] = 32'hFFFF_FFFF;
    va[6] = 32'h8000_0000;   vb[6] = 32'd1024;  ve[6] = 32'h8000_0000;
    va[7] = 32'h7FFF_FFFF;   vb[7] = 32'd2048;
    va[8] = 32'h8000_0000;   vb[8] = 32'd2048;
`ifdef FIXMUL_SAT_EN
    ve[7] = 32'h7FFF_FFFF;
    ve[8] = 32'h8000_0000;
`else
    ve[7] = 32'hFFFF_FFFE;
    ve[8] = 32'h0000_0000;
`endif

    repeat (3) @(negedge clock);
    #1;
    chk("rst_product", product, 32'd0);
    chk("rst_vout", {31'd0, valid_out}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    #1;
    chk("rst_ready", {31'd0, ready_in}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      issue(va[i], vb[i], ve[i]);
      wait_done();
    end

    // Backpressure: hold the result for five cycles.
    @(negedge clock);
    ready_out = 1'b0;
    issue(32'd2560, 32'd1024, 32'd2560);
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (!valid_out && n < 100);
    for (int i = 0; i < 5; i++) begin
      chk("bp_vout", {31'd0, valid_out}, 32'd1);
      chk("bp_product", product, 32'd2560);
      chk("bp_ready_in", {31'd0, ready_in}, 32'd0);
      @(negedge clock);
      multiplicand = 32'd7777;
      multiplier   = 32'd9999;
      valid_in     = 1'b1;
      #1;
    end
    @(negedge clock);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    wait_done();
    issue(-32'sd3072, 32'd1024, -32'sd3072);
    wait_done();

    // Abort mid-BUSY at count 15.
    issue(32'd5120, 32'd7168, 32'd35840);
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_vout", {31'd0, valid_out}, 32'd0);
    chk("abort_product", product, 32'd0);
    dropped = q.pop_back();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_ready", {31'd0, ready_in}, 32'd1);
    repeat (40) @(negedge clock);
    #1;
    chk("abort_no_out", {31'd0, valid_out}, 32'd0);
    issue(32'd3072, 32'd3072, 32'd9216);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, fail_n);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
